// File: rtl/kbd_move_sequencer_if.sv
// Keyboard move sequencer bus: scan-code/frame strobes in, move command out.
interface kbd_move_sequencer_if;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       frame_tick;
   logic [2:0] move;
   logic       move_valid;
   logic [3:0] held;

   // Producer side: PS/2 receiver, frame timer and the move consumer.
   modport master (
      output rx_data, rx_done_tick, frame_tick,
      input  move, move_valid, held
   );

   // Sequencer side.
   modport slave (
      input  rx_data, rx_done_tick, frame_tick,
      output move, move_valid, held
   );
endinterface

// File: rtl/kbd_move_sequencer.sv
// Parses PS/2 scan codes into a four-direction held-key map and issues at most
// one registered move per frame tick, with auto-repeat while a key stays held.
module kbd_move_sequencer #(
   parameter int unsigned REPEAT_FRAMES = 8,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   kbd_move_sequencer_if.slave  bus
);

   localparam logic [7:0]       CODE_EXT  = 8'hE0;
   localparam logic [7:0]       CODE_BRK  = 8'hF0;
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXT    = 2'd1,
      ST_BRK    = 2'd2,
      ST_EXTBRK = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       move_q, move_d;
   logic             move_valid_q, move_valid_d;
   logic [3:0]       held_q, held_d;
   logic             pending_q, pending_d;
   logic [2:0]       pend_dir_q, pend_dir_d;
   logic [2:0]       last_dir_q, last_dir_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;

   logic             make_c;
   logic             brk_c;
   logic [2:0]       ev_dir_c;
   logic [3:0]       ev_mask_c;

   // WASD set-2 codes -> direction (1=up, 2=down, 3=left, 4=right, 0=none).
   function automatic logic [2:0] plain_dir(input logic [7:0] code);
      case (code)
         8'h1D:   plain_dir = 3'd1;
         8'h1B:   plain_dir = 3'd2;
         8'h1C:   plain_dir = 3'd3;
         8'h23:   plain_dir = 3'd4;
         default: plain_dir = 3'd0;
      endcase
   endfunction

   // E0-extended arrow codes -> direction.
   function automatic logic [2:0] ext_dir(input logic [7:0] code);
      case (code)
         8'h75:   ext_dir = 3'd1;
         8'h72:   ext_dir = 3'd2;
         8'h6B:   ext_dir = 3'd3;
         8'h74:   ext_dir = 3'd4;
         default: ext_dir = 3'd0;
      endcase
   endfunction

   function automatic logic [3:0] dir_mask(input logic [2:0] dir);
      case (dir)
         3'd1:    dir_mask = 4'b0001;
         3'd2:    dir_mask = 4'b0010;
         3'd3:    dir_mask = 4'b0100;
         3'd4:    dir_mask = 4'b1000;
         default: dir_mask = 4'b0000;
      endcase
   endfunction

   // Highest-priority held direction: up > down > left > right.
   function automatic logic [2:0] top_dir(input logic [3:0] map);
      if (map[0])      top_dir = 3'd1;
      else if (map[1]) top_dir = 3'd2;
      else if (map[2]) top_dir = 3'd3;
      else if (map[3]) top_dir = 3'd4;
      else             top_dir = 3'd0;
   endfunction

   // Parser next state and make/break event decode; advances only on a byte.
   always_comb begin
      state_d  = state_q;
      make_c   = 1'b0;
      brk_c    = 1'b0;
      ev_dir_c = 3'd0;
      if (bus.rx_done_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.rx_data == CODE_EXT) begin
                  state_d = ST_EXT;
               end else if (bus.rx_data == CODE_BRK) begin
                  state_d = ST_BRK;
               end else begin
                  ev_dir_c = plain_dir(bus.rx_data);
                  make_c   = (ev_dir_c != 3'd0);
               end
            end
            ST_EXT: begin
               if (bus.rx_data == CODE_BRK) begin
                  state_d = ST_EXTBRK;
               end else if (bus.rx_data == CODE_EXT) begin
                  state_d = ST_EXT;
               end else begin
                  ev_dir_c = ext_dir(bus.rx_data);
                  make_c   = (ev_dir_c != 3'd0);
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               ev_dir_c = plain_dir(bus.rx_data);
               brk_c    = (ev_dir_c != 3'd0);
               state_d  = ST_IDLE;
            end
            default: begin
               ev_dir_c = ext_dir(bus.rx_data);
               brk_c    = (ev_dir_c != 3'd0);
               state_d  = ST_IDLE;
            end
         endcase
      end
   end

   assign ev_mask_c = dir_mask(ev_dir_c);

   // Frame emission first from pre-byte state, then key events layered on top
   // so a coincident byte only takes effect from the next frame tick.
   always_comb begin
      move_d       = move_q;
      move_valid_d = 1'b0;
      held_d       = held_q;
      pending_d    = pending_q;
      pend_dir_d   = pend_dir_q;
      last_dir_d   = last_dir_q;
      rcnt_d       = rcnt_q;

      if (bus.frame_tick) begin
         if (pending_q) begin
            move_d       = pend_dir_q;
            move_valid_d = 1'b1;
            pending_d    = 1'b0;
            rcnt_d       = '0;
         end else if (last_dir_q != 3'd0) begin
            if (rcnt_q == RPT_LAST) begin
               move_d       = last_dir_q;
               move_valid_d = 1'b1;
               rcnt_d       = '0;
            end else begin
               rcnt_d = rcnt_q + CNT_W'(1);
            end
         end else begin
            rcnt_d = '0;
         end
      end

      if (make_c) begin
         held_d = held_q | ev_mask_c;
         if (ev_dir_c != last_dir_q) begin
            last_dir_d = ev_dir_c;
            pending_d  = 1'b1;
            pend_dir_d = ev_dir_c;
         end
      end

      // pending survives a break so a sub-frame tap still moves once.
      if (brk_c) begin
         held_d = held_q & ~ev_mask_c;
         if (ev_dir_c == last_dir_q) begin
            last_dir_d = top_dir(held_q & ~ev_mask_c);
            rcnt_d     = '0;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         move_q       <= 3'd0;
         move_valid_q <= 1'b0;
         held_q       <= 4'd0;
         pending_q    <= 1'b0;
         pend_dir_q   <= 3'd0;
         last_dir_q   <= 3'd0;
         rcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         move_q       <= move_d;
         move_valid_q <= move_valid_d;
         held_q       <= held_d;
         pending_q    <= pending_d;
         pend_dir_q   <= pend_dir_d;
         last_dir_q   <= last_dir_d;
         rcnt_q       <= rcnt_d;
      end
   end

   assign bus.move       = move_q;
   assign bus.move_valid = move_valid_q;
   assign bus.held       = held_q;

endmodule
